// File: rtl/seg_score_display.sv
// Binary score to BCD converter (shift-and-add-3) driving a multiplexed
// active-low seven-segment display with optional leading-zero blanking.
module seg_score_display #(
   parameter int BIN_W       = 16,
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 100000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [BIN_W-1:0]      bin,
   input  logic                  load,
   input  logic                  blank_lz,
   output logic                  busy,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     an
);

   localparam int SCR_D  = (BIN_W + 2) / 3;
   localparam int CNT_W  = $clog2(BIN_W + 1);
   localparam int SCAN_W = $clog2(REFRESH_DIV);
   localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                state_reg, state_next;
   logic [BIN_W-1:0]      sh_reg, sh_next;
   logic [4*SCR_D-1:0]    scr_reg, scr_next, scr_adj;
   logic [CNT_W-1:0]      cnt_reg, cnt_next;
   logic                  busy_reg, busy_next;
   logic [4*DIGITS-1:0]   bcd_reg, bcd_next, res_low;
   logic                  ovf_reg, ovf_next, res_ovf;
   logic [SCR_D-1:0]      hi_nz;
   logic [SCAN_W-1:0]     scan_reg;
   logic [IDX_W-1:0]      idx_reg;
   logic [3:0]            dig;
   logic                  upper_zero;
   logic [6:0]            seg_dec;

   genvar gi;
   generate
      for (gi = 0; gi < SCR_D; gi++) begin : g_scr
         assign scr_adj[4*gi +: 4] = (scr_reg[4*gi +: 4] >= 4'd5) ?
                                     scr_reg[4*gi +: 4] + 4'd3 : scr_reg[4*gi +: 4];
         // Scratch digits beyond the display width only feed overflow.
         if (gi >= DIGITS) begin : g_hi
            assign hi_nz[gi] = (scr_reg[4*gi +: 4] != 4'd0);
         end else begin : g_lo
            assign hi_nz[gi] = 1'b0;
         end
      end
      for (gi = 0; gi < DIGITS; gi++) begin : g_res
         if (gi < SCR_D) begin : g_have
            assign res_low[4*gi +: 4] = scr_reg[4*gi +: 4];
         end else begin : g_pad
            assign res_low[4*gi +: 4] = 4'd0;
         end
         assign an[gi] = (idx_reg != IDX_W'(gi));
      end
   endgenerate

   assign res_ovf = |hi_nz;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         sh_reg    <= '0;
         scr_reg   <= '0;
         cnt_reg   <= '0;
         busy_reg  <= 1'b0;
         bcd_reg   <= '0;
         ovf_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         sh_reg    <= sh_next;
         scr_reg   <= scr_next;
         cnt_reg   <= cnt_next;
         busy_reg  <= busy_next;
         bcd_reg   <= bcd_next;
         ovf_reg   <= ovf_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      sh_next    = sh_reg;
      scr_next   = scr_reg;
      cnt_next   = cnt_reg;
      busy_next  = busy_reg;
      bcd_next   = bcd_reg;
      ovf_next   = ovf_reg;
      case (state_reg)
         IDLE: begin
            if (load) begin
               sh_next    = bin;
               scr_next   = '0;
               cnt_next   = '0;
               busy_next  = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            {scr_next, sh_next} = {scr_adj, sh_reg} << 1;
            if (cnt_reg == CNT_W'(BIN_W - 1)) begin
               state_next = DONE;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         DONE: begin
            ovf_next   = res_ovf;
            bcd_next   = res_ovf ? {DIGITS{4'h9}} : res_low;
            busy_next  = 1'b0;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Scan timing is free-running and never waits on the converter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scan_reg <= '0;
         idx_reg  <= '0;
      end else if (scan_reg == SCAN_W'(REFRESH_DIV - 1)) begin
         scan_reg <= '0;
         idx_reg  <= (idx_reg == IDX_W'(DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);
      end else begin
         scan_reg <= scan_reg + SCAN_W'(1);
      end
   end

   always_comb begin
      dig        = 4'd0;
      upper_zero = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (IDX_W'(i) == idx_reg) dig = bcd_reg[4*i +: 4];
         if (IDX_W'(i) >= idx_reg && bcd_reg[4*i +: 4] != 4'd0) upper_zero = 1'b0;
      end
   end

   always_comb begin
      case (dig)
         4'd0:    seg_dec = 7'b1000000;
         4'd1:    seg_dec = 7'b1111001;
         4'd2:    seg_dec = 7'b0100100;
         4'd3:    seg_dec = 7'b0110000;
         4'd4:    seg_dec = 7'b0011001;
         4'd5:    seg_dec = 7'b0010010;
         4'd6:    seg_dec = 7'b0000010;
         4'd7:    seg_dec = 7'b1111000;
         4'd8:    seg_dec = 7'b0000000;
         4'd9:    seg_dec = 7'b0010000;
         default: seg_dec = 7'b1111111;
      endcase
   end

   assign seg      = (blank_lz && idx_reg != '0 && upper_zero) ? 7'b1111111 : seg_dec;
   assign busy     = busy_reg;
   assign bcd      = bcd_reg;
   assign overflow = ovf_reg;

endmodule

// File: tb/tb_seg_score_display.sv
// Scoreboard bench for seg_score_display: conversions, busy timing,
// saturation, display scan/blanking and asynchronous reset.
module tb_seg_score_display;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] bin;
   logic        load;
   logic        blank_lz;
   logic        busy;
   logic [15:0] bcd;
   logic        overflow;
   logic [6:0]  seg;
   logic [3:0]  an;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [15:0] bcd;
      logic        ovf;
      int          val;
   } exp_t;

   exp_t exp_q[$];

   seg_score_display #(.BIN_W(16), .DIGITS(4), .REFRESH_DIV(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .bin      (bin),
      .load     (load),
      .blank_lz (blank_lz),
      .busy     (busy),
      .bcd      (bcd),
      .overflow (overflow),
      .seg      (seg),
      .an       (an)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input int v);
      exp_t e;
      int   t;
      e.val = v;
      e.bcd = 16'h0;
      if (v > 9999) begin
         e.bcd = 16'h9999;
         e.ovf = 1'b1;
      end else begin
         e.ovf = 1'b0;
         t = v;
         for (int i = 0; i < 4; i++) begin
            e.bcd[4*i +: 4] = 4'(t % 10);
            t = t / 10;
         end
      end
      return e;
   endfunction

   function automatic logic [6:0] exp_seg(input logic [15:0] b, input int idx, input logic blz);
      logic [15:0] hi;
      logic [3:0]  d;
      hi = b >> (4 * idx);
      d  = hi[3:0];
      if (blz && idx != 0 && hi == 16'h0) return 7'b1111111;
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         default: return 7'b0010000;
      endcase
   endfunction

   // Completion monitor: every falling edge of busy retires one expected result.
   initial begin
      logic busy_prev;
      exp_t e;
      busy_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            busy_prev = 1'b0;
         end else begin
            if (busy_prev && !busy) begin
               check("result_pending", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check($sformatf("bcd(%0d)", e.val), 32'(bcd), 32'(e.bcd));
                  check($sformatf("ovf(%0d)", e.val), 32'(overflow), 32'(e.ovf));
                  $display("[TB] conv bin=%0d bcd=%h ovf=%0b", e.val, bcd, overflow);
               end
            end
            busy_prev = busy;
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic convert(input int v);
      @(negedge clk);
      bin  = 16'(v);
      load = 1'b1;
      exp_q.push_back(model(v));
      @(negedge clk);
      load = 1'b0;
      wait_idle();
      @(negedge clk);
   endtask

   task automatic scan_check(input int v, input logic blz);
      logic [3:0]  prev_an;
      logic [15:0] b;
      int          guard = 0;
      exp_t        e;
      e        = model(v);
      b        = e.bcd;
      blank_lz = blz;
      prev_an  = an;
      while (!(an == 4'b1110 && prev_an != 4'b1110) && guard < 64) begin
         prev_an = an;
         @(negedge clk);
         guard++;
      end
      check("scan_align", 32'(guard < 64), 32'd1);
      for (int k = 0; k < 16; k++) begin
         check($sformatf("an(v=%0d,k=%0d)", v, k), 32'(an), 32'(4'b1111 ^ (4'b0001 << (k / 4))));
         check($sformatf("seg(v=%0d,blz=%0b,k=%0d)", v, blz, k), 32'(seg), 32'(exp_seg(b, k / 4, blz)));
         @(negedge clk);
      end
      $display("[TB] scan bin=%0d blank_lz=%0b", v, blz);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst      = 1'b1;
      load     = 1'b0;
      bin      = 16'h0;
      blank_lz = 1'b0;

      // Reset values, then first load accepted on the first edge after release.
      #2 rst = 1'b0;
      #1;
      check("rst_an", 32'(an), 32'(4'b1110));
      check("rst_seg", 32'(seg), 32'(7'b1000000));
      check("rst_bcd", 32'(bcd), 32'h0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      repeat (3) @(negedge clk);
      bin  = 16'd321;
      load = 1'b1;
      exp_q.push_back(model(321));
      #2 rst = 1'b1;
      @(negedge clk);
      check("first_load", 32'(busy), 32'd1);
      load = 1'b0;
      wait_idle();

      // Busy lasts 17 samples; a load right after busy falls is accepted.
      @(negedge clk);
      bin  = 16'd1234;
      load = 1'b1;
      exp_q.push_back(model(1234));
      @(negedge clk);
      load = 1'b0;
      n = 0;
      while (busy && n < 40) begin
         n++;
         @(negedge clk);
      end
      check("busy_cycles", 32'(n), 32'd17);
      bin  = 16'd55;
      load = 1'b1;
      exp_q.push_back(model(55));
      @(negedge clk);
      check("reload_edge18", 32'(busy), 32'd1);
      load = 1'b0;
      wait_idle();

      // Load sampled in the cycle busy falls is dropped.
      @(negedge clk);
      bin  = 16'd1234;
      load = 1'b1;
      exp_q.push_back(model(1234));
      @(negedge clk);
      load = 1'b0;
      repeat (16) @(negedge clk);
      check("busy_edge16", 32'(busy), 32'd1);
      bin  = 16'd77;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      check("busy_edge17", 32'(busy), 32'd0);
      @(negedge clk);
      check("done_load_ignored", 32'(busy), 32'd0);

      // Load during conversion is ignored and bin changes have no effect.
      @(negedge clk);
      bin  = 16'd5;
      load = 1'b1;
      exp_q.push_back(model(5));
      @(negedge clk);
      load = 1'b0;
      repeat (3) @(negedge clk);
      bin  = 16'd42;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);
      check("no_second_conv", 32'(busy), 32'd0);

      // Saturation boundaries and assorted values.
      convert(65535);
      convert(9999);
      convert(10000);
      convert(0);
      convert(100);
      convert(4096);
      for (int i = 0; i < 4; i++) convert(int'($urandom_range(0, 65535)));

      // Display scan and leading-zero blanking.
      convert(7);
      scan_check(7, 1'b1);
      scan_check(7, 1'b0);
      convert(1002);
      scan_check(1002, 1'b1);
      convert(50);
      scan_check(50, 1'b1);

      // Asynchronous reset in the middle of a conversion.
      @(negedge clk);
      bin  = 16'd1234;
      load = 1'b1;
      exp_q.push_back(model(1234));
      @(negedge clk);
      load = 1'b0;
      repeat (7) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      exp_q.delete();
      #1;
      check("mid_rst_an", 32'(an), 32'(4'b1110));
      check("mid_rst_seg", 32'(seg), 32'(7'b1000000));
      check("mid_rst_bcd", 32'(bcd), 32'h0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_bcd", 32'(bcd), 32'h0);
      check("post_rst_busy", 32'(busy), 32'd0);
      blank_lz = 1'b0;
      convert(1234);
      convert(8765);

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_score_display.md
SEG_SCORE_DISPLAY -- requirements
Module: seg_score_display

Interface
REQ-001 The block SHALL have parameter BIN_W, default 16, giving the binary score width.
REQ-002 The block SHALL have parameter DIGITS, default 4, giving the number of displayed decimal digits and anodes.
REQ-003 The block SHALL have parameter REFRESH_DIV, default 100000, giving the clk cycles each digit stays lit; legal range is 2 or more.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port bin, input, BIN_W bits: the binary score to convert.
REQ-007 The block SHALL have port load, input, 1 bit: a one-cycle request to sample bin and start conversion.
REQ-008 The block SHALL have port blank_lz, input, 1 bit: the leading-zero blanking enable.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-010 The block SHALL have port bcd, output, 4*DIGITS bits: the last completed result; digit i occupies bcd[4i+3:4i]; digit 0 is the least significant.
REQ-011 The block SHALL have port overflow, output, 1 bit: set when the last result exceeded 10^DIGITS-1.
REQ-012 The block SHALL have port seg, output, 7 bits: active-low segments, with seg[0]=a through seg[6]=g.
REQ-013 The block SHALL have port an, output, DIGITS bits: active-low one-hot anode select; an[0] is the rightmost digit (digit 0).

Function
REQ-014 The converter FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-015 In IDLE, load=1 SHALL capture bin into the shift register, clear the BCD scratch to zero, set the iteration count to 0, go to SHIFT and assert busy on the next edge.
REQ-016 The BCD scratch SHALL hold at least ceil(BIN_W/3) digits, independent of DIGITS.
REQ-017 In SHIFT, each cycle SHALL first add 3 to every scratch digit that is 5 or more, then shift {scratch, shift register} left by one bit.
REQ-018 After exactly BIN_W SHIFT cycles, the FSM SHALL go to DONE.
REQ-019 In DONE, overflow SHALL be set to 1 if any scratch digit at index DIGITS or above is nonzero, else 0.
REQ-020 In DONE, bcd SHALL load the low DIGITS scratch digits, or all digits = 9 if overflow is set (saturation).
REQ-021 In DONE, the FSM SHALL return to IDLE and busy SHALL drop on the same edge.
REQ-022 Latency SHALL be as follows: with load sampled at edge 0, busy is high from edge 1 through edge BIN_W+1, bcd and overflow update at edge BIN_W+1, and busy is low after edge BIN_W+1.
REQ-023 bcd and overflow SHALL hold their values between conversions; intermediate scratch values SHALL never appear on bcd.
REQ-024 load while busy=1 SHALL be ignored, not queued; load sampled in the same cycle busy falls SHALL be ignored, and load in any later IDLE cycle SHALL be accepted.
REQ-025 bin SHALL only be sampled on an accepted load; changes to bin during conversion SHALL have no effect.
REQ-026 The scan counter SHALL count 0..REFRESH_DIV-1 continuously and wrap to 0.
REQ-027 On each scan-counter wrap, the digit index SHALL advance by 1 modulo DIGITS (DIGITS-1 wraps to 0).
REQ-028 an SHALL be all ones except a 0 at the bit equal to the digit index.
REQ-029 seg SHALL be the active-low decode of the selected bcd digit: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-030 Blanking: if blank_lz=1, the digit index is nonzero, and the selected digit and all higher digits are zero, seg SHALL be 1111111; digit 0 is never blanked.
REQ-031 Scanning SHALL run independently of conversion; bcd updates SHALL take effect on seg in the same cycle the new bcd is visible.
REQ-032 seg and an SHALL be registered or derived only from registered state, so no combinational path runs from bin or load to seg or an.

Reset
REQ-033 While rst=0, the block SHALL force, asynchronously: FSM=IDLE, busy=0, bcd=0, overflow=0, scan counter=0, digit index=0, an={DIGITS-1 ones, 0}, seg=1000000.
REQ-034 Reset asserted mid-conversion SHALL abort the conversion; no partial result SHALL appear, and bcd SHALL read 0 after release.
REQ-035 On release, the first load SHALL be accepted on the first rising edge after rst returns high.

Verification
REQ-036 Reset: assert rst=0 asynchronously mid-cycle -> same-instant an=1110, seg=1000000, bcd=0000, busy=0.
REQ-037 Conversion: bin=1234, one-cycle load -> busy high for 17 cycles; bcd=0x1234 and overflow=0 at edge 17; a further load is accepted from edge 18.
REQ-038 Saturation: bin=65535 -> bcd=0x9999, overflow=1; then bin=9999 -> bcd=0x9999, overflow=0.
REQ-039 Busy rule: bin=5, load; at edge 4 apply bin=42 with load again -> result bcd=0x0005; no second conversion occurs.
REQ-040 Scan and blanking: REFRESH_DIV=4, bin=7, blank_lz=1 -> an steps 1110, 1101, 1011, 0111 every 4 cycles; seg=1111000 on an[0] and 1111111 on the other anodes; with blank_lz=0, seg=1000000 on the other anodes.
REQ-041 Mid-conversion reset: rst=0 at edge 8 of a bin=1234 conversion -> after release bcd=0, busy=0, and a new load converts correctly.
